// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic {
    MEM_SRC_INSTR = 1'b0,
    MEM_SRC_DATA  = 1'b1
  } mem_src_e;

  localparam int unsigned MEM_MAX_OUTSTANDING = 2;
  localparam int unsigned MEM_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order FIFO of source tags for granted-but-unanswered memory transactions.
module mem_tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_MAX_OUTSTANDING,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  mem_src_e      src_i,
  input  logic          pop_i,
  output mem_src_e      head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  mem_src_e        tags_q [2**AW];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [PW-1:0]   wrPtr_d, rdPtr_d;
  logic [PW-1:0]   fill;

  // Pointers carry one extra wrap bit so their difference is the fill level.
  assign wrPtr_d = push_i ? wrPtr_q + 1'b1 : wrPtr_q;
  assign rdPtr_d = pop_i  ? rdPtr_q + 1'b1 : rdPtr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) tags_q[wrPtr_q[AW-1:0]] <= src_i;
  end

  assign fill    = wrPtr_q - rdPtr_q;
  assign count_o = CW'(fill);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (fill == PW'(DEPTH));
  assign head_o  = tags_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data, data-first with a fetch anti-starvation limit.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = MEM_MAX_OUTSTANDING,
  parameter int unsigned MAX_DATA_STREAK = MEM_MAX_DATA_STREAK
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic        protocol_err_o
);

  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);

  mem_src_e      winner, headSrc;
  mem_src_e      lockedSrc_q, lockedSrc_d;
  logic          locked_q, locked_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          protocolErr_q, protocolErr_d;
  logic          handshake, respValid, fifoFull, fifoEmpty;

  // A stalled request keeps its winner so the memory sees stable fields.
  always_comb begin
    winner = MEM_SRC_INSTR;
    if (locked_q)
      winner = lockedSrc_q;
    else if (instr_req_i && data_req_i && streak_q == SW'(MAX_DATA_STREAK))
      winner = MEM_SRC_INSTR;
    else if (data_req_i)
      winner = MEM_SRC_DATA;
  end

  assign mem_req_o = (instr_req_i | data_req_i) & ~fifoFull;
  assign handshake = mem_req_o & mem_gnt_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o && winner == MEM_SRC_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else if (mem_req_o) begin
      mem_addr_o  = instr_addr_i;
      mem_be_o    = 4'hF;
    end
  end

  assign instr_gnt_o = handshake & (winner == MEM_SRC_INSTR);
  assign data_gnt_o  = handshake & (winner == MEM_SRC_DATA);

  // Responses with nothing in flight are dropped and flagged instead of routed.
  assign respValid      = mem_rvalid_i & ~fifoEmpty;
  assign instr_rvalid_o = respValid & (headSrc == MEM_SRC_INSTR);
  assign data_rvalid_o  = respValid & (headSrc == MEM_SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign protocol_err_o = protocolErr_q;

  mem_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .src_i   (winner),
    .pop_i   (respValid),
    .head_o  (headSrc),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (outstanding_o)
  );

  always_comb begin
    locked_d      = locked_q;
    lockedSrc_d   = lockedSrc_q;
    streak_d      = streak_q;
    protocolErr_d = protocolErr_q | (mem_rvalid_i & fifoEmpty);
    if (handshake) begin
      locked_d = 1'b0;
    end else if (mem_req_o) begin
      locked_d    = 1'b1;
      lockedSrc_d = winner;
    end
    if (!instr_req_i || instr_gnt_o)
      streak_d = '0;
    else if (data_gnt_o && streak_q != SW'(MAX_DATA_STREAK))
      streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q      <= 1'b0;
      lockedSrc_q   <= MEM_SRC_INSTR;
      streak_q      <= '0;
      protocolErr_q <= 1'b0;
    end else begin
      locked_q      <= locked_d;
      lockedSrc_q   <= lockedSrc_d;
      streak_q      <= streak_d;
      protocolErr_q <= protocolErr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard checked by a separate monitor.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct {
    mem_src_e    src;
    logic [31:0] rdata;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i, data_req_i, data_we_i, mem_gnt_i, mem_rvalid_i;
  logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
  logic [3:0]  data_be_i;
  logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic        mem_req_o, mem_we_o, protocol_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  outstanding_o;

  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t sbQ[$];

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .MAX_DATA_STREAK(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Inputs change on the falling edge and settle well before the next rising edge.
  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                               input logic dReq, input logic [31:0] dAddr, input logic dWe,
                               input logic [3:0] dBe, input logic [31:0] dWdata,
                               input logic gnt, input logic rv, input logic [31:0] rd);
    @(negedge clk_i);
    instr_req_i  = iReq;  instr_addr_i = iAddr;
    data_req_i   = dReq;  data_addr_i  = dAddr;  data_we_i = dWe;
    data_be_i    = dBe;   data_wdata_i = dWdata;
    mem_gnt_i    = gnt;   mem_rvalid_i = rv;     mem_rdata_i = rd;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic expectResp(input mem_src_e src, input logic [31:0] rd);
    exp_t e;
    e.src = src;
    e.rdata = rd;
    sbQ.push_back(e);
  endtask

  // Every response the DUT routes must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (instr_rvalid_o && data_rvalid_o)
        checkOutput("rvalid_onehot", 32'd2, 32'd1);
      else if (instr_rvalid_o || data_rvalid_o) begin
        if (sbQ.size() == 0)
          checkOutput("unexpected_rvalid", {31'd0, data_rvalid_o}, {31'd0, ~data_rvalid_o});
        else begin
          e = sbQ.pop_front();
          checkOutput("resp_src", {31'd0, data_rvalid_o}, {31'd0, e.src});
          checkOutput("resp_rdata", data_rvalid_o ? data_rdata_o : instr_rdata_o, e.rdata);
        end
      end
    end
  end

  initial begin
    logic expD [6];
    logic prevD;
    expD = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_ni = 1'b0;
    instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0; data_we_i = 0;
    data_be_i = 0; data_wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    checkOutput("rst_outstanding", {30'd0, outstanding_o}, 32'd0);
    checkOutput("rst_err", {31'd0, protocol_err_o}, 32'd0);
    checkOutput("rst_be", {28'd0, mem_be_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single fetch
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("fetch_gnt", {31'd0, instr_gnt_o}, 32'd1);
    checkOutput("fetch_dgnt", {31'd0, data_gnt_o}, 32'd0);
    checkOutput("fetch_addr", mem_addr_o, 32'h100);
    checkOutput("fetch_we", {31'd0, mem_we_o}, 32'd0);
    checkOutput("fetch_be", {28'd0, mem_be_o}, 32'hF);
    expectResp(MEM_SRC_INSTR, 32'h13);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h13);
    checkOutput("fetch_outst1", {30'd0, outstanding_o}, 32'd1);
    idleCycle();
    checkOutput("fetch_outst0", {30'd0, outstanding_o}, 32'd0);

    // Contention: four data grants, then the fetch is forced through
    prevD = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) expectResp(prevD ? MEM_SRC_DATA : MEM_SRC_INSTR, 32'hA000_0000 + k);
      applyStimulus(1'b1, 32'h200, 1'b1, 32'h2000, 1'b0, 4'hF, 32'h0, 1'b1, k > 0, 32'hA000_0000 + k);
      checkOutput($sformatf("cont_dgnt%0d", k), {31'd0, data_gnt_o}, {31'd0, expD[k]});
      checkOutput($sformatf("cont_ignt%0d", k), {31'd0, instr_gnt_o}, {31'd0, ~expD[k]});
      checkOutput($sformatf("cont_addr%0d", k), mem_addr_o, expD[k] ? 32'h2000 : 32'h200);
      prevD = expD[k];
    end
    expectResp(MEM_SRC_DATA, 32'hA000_0006);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hA000_0006);
    idleCycle();
    checkOutput("cont_outst0", {30'd0, outstanding_o}, 32'd0);

    // Lock held by data while fetch arrives mid-wait
    applyStimulus(1'b0, 32'h300, 1'b1, 32'h2000, 1'b1, 4'hF, 32'h55, 1'b0, 1'b0, 32'h0);
    checkOutput("lockd_addr0", mem_addr_o, 32'h2000);
    checkOutput("lockd_gnt0", {31'd0, data_gnt_o}, 32'd0);
    for (int k = 1; k < 3; k++) begin
      applyStimulus(1'b1, 32'h300, 1'b1, 32'h2000, 1'b1, 4'hF, 32'h55, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("lockd_addr%0d", k), mem_addr_o, 32'h2000);
      checkOutput($sformatf("lockd_gnts%0d", k), {30'd0, instr_gnt_o, data_gnt_o}, 32'd0);
    end
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h2000, 1'b1, 4'hF, 32'h55, 1'b1, 1'b0, 32'h0);
    checkOutput("lockd_dgnt", {31'd0, data_gnt_o}, 32'd1);
    checkOutput("lockd_wdata", mem_wdata_o, 32'h55);
    expectResp(MEM_SRC_DATA, 32'hB1);
    applyStimulus(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hB1);
    checkOutput("lockd_igrant", {31'd0, instr_gnt_o}, 32'd1);
    checkOutput("lockd_iaddr", mem_addr_o, 32'h300);
    expectResp(MEM_SRC_INSTR, 32'hB2);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hB2);

    // Lock held by fetch even though data would otherwise win
    applyStimulus(1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("locki_addr0", mem_addr_o, 32'h400);
    applyStimulus(1'b1, 32'h400, 1'b1, 32'h2400, 1'b1, 4'h1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("locki_addr1", mem_addr_o, 32'h400);
    checkOutput("locki_we1", {31'd0, mem_we_o}, 32'd0);
    applyStimulus(1'b1, 32'h400, 1'b1, 32'h2400, 1'b1, 4'h1, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("locki_igrant", {30'd0, instr_gnt_o, data_gnt_o}, 32'd2);
    expectResp(MEM_SRC_INSTR, 32'hC1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h2400, 1'b1, 4'h1, 32'h0, 1'b1, 1'b1, 32'hC1);
    checkOutput("locki_dgrant", {31'd0, data_gnt_o}, 32'd1);
    expectResp(MEM_SRC_DATA, 32'hC2);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hC2);

    // Full: no bypass when a response frees a slot in the same cycle
    applyStimulus(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_dgnt", {31'd0, data_gnt_o}, 32'd1);
    applyStimulus(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_outst2", {30'd0, outstanding_o}, 32'd2);
    checkOutput("full_req0", {31'd0, mem_req_o}, 32'd0);
    expectResp(MEM_SRC_INSTR, 32'hD1);
    applyStimulus(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hD1);
    checkOutput("full_nobypass", {30'd0, mem_req_o, instr_gnt_o}, 32'd0);
    applyStimulus(1'b1, 32'h504, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("full_outst1", {30'd0, outstanding_o}, 32'd1);
    checkOutput("full_regrant", {30'd0, mem_req_o, instr_gnt_o}, 32'd3);
    expectResp(MEM_SRC_DATA, 32'hD2);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hD2);
    expectResp(MEM_SRC_INSTR, 32'hD3);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hD3);

    // Interleaved I / D-write / I with in-order routing
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("ilv_i0", {31'd0, instr_gnt_o}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 4'h3, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0);
    checkOutput("ilv_dwe", {31'd0, mem_we_o}, 32'd1);
    checkOutput("ilv_dbe", {28'd0, mem_be_o}, 32'h3);
    checkOutput("ilv_dwdata", mem_wdata_o, 32'hCAFE_F00D);
    expectResp(MEM_SRC_INSTR, 32'hE1);
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hE1);
    expectResp(MEM_SRC_DATA, 32'hE2);
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hE2);
    checkOutput("ilv_i4", {31'd0, instr_gnt_o}, 32'd1);
    expectResp(MEM_SRC_INSTR, 32'hE3);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hE3);
    idleCycle();
    checkOutput("ilv_outst0", {30'd0, outstanding_o}, 32'd0);
    checkOutput("sb_drained", sbQ.size(), 32'd0);

    // Protocol error, sticky, then reset with one transaction in flight
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'hBAD);
    checkOutput("err_norv", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    checkOutput("err_pre", {31'd0, protocol_err_o}, 32'd0);
    idleCycle();
    checkOutput("err_set", {31'd0, protocol_err_o}, 32'd1);
    applyStimulus(1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("err_sticky", {31'd0, protocol_err_o}, 32'd1);
    idleCycle();
    checkOutput("prerst_outst", {30'd0, outstanding_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_outst", {30'd0, outstanding_o}, 32'd0);
    checkOutput("midrst_err", {31'd0, protocol_err_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1234);
    checkOutput("late_norv", {30'd0, instr_rvalid_o, data_rvalid_o}, 32'd0);
    idleCycle();
    checkOutput("late_err", {31'd0, protocol_err_o}, 32'd1);
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
